// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the Mackerel interrupt controller.
// Consumers: irq_ctrl_if, irq_ctrl, irq_timer.
package irq_ctrl_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_AVEC = 2'd1;
    localparam logic [1:0] REG_TCTL = 2'd2;
    localparam logic [1:0] REG_PEND = 2'd3;

    typedef logic [2:0] level_t;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        AVEC,
        VEC,
        SPUR
    } resp_t;

    // Bit 0 of the set is unused; level 0 means "nothing pending".
    function automatic level_t highest_level(input logic [7:0] set);
        level_t top;
        top = '0;
        for (int l = 1; l < 8; l++) begin
            if (set[l]) top = level_t'(l);
        end
        return top;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side and register-side signal bundle for irq_ctrl.
// master = CPU/decoder side, slave = the interrupt controller.
interface irq_ctrl_if #(
    parameter int NUM_SRC = 4
);
    import irq_ctrl_pkg::*;

    logic [NUM_SRC-1:0] IRQ_N;
    logic               AS_N;
    logic [2:0]         FC;
    level_t             ADDR_L;
    logic               REG_WE;
    logic [1:0]         REG_ADDR;
    logic [7:0]         REG_WDATA;
    logic [7:0]         REG_RDATA;
    logic [2:0]         IPL_N;
    logic [NUM_SRC-1:0] IACK_N;
    logic               VPA_N;
    logic               BERR_N;

    modport master (
        output IRQ_N, AS_N, FC, ADDR_L, REG_WE, REG_ADDR, REG_WDATA,
        input  REG_RDATA, IPL_N, IACK_N, VPA_N, BERR_N
    );

    modport slave (
        input  IRQ_N, AS_N, FC, ADDR_L, REG_WE, REG_ADDR, REG_WDATA,
        output REG_RDATA, IPL_N, IACK_N, VPA_N, BERR_N
    );

endinterface

// File: rtl/irq_timer.sv
// Periodic tick source: counts TIMER_DIV clocks while enabled and latches a pending flag.
// Instantiated by irq_ctrl only when IRQ_CTRL_TIMER_EN is defined.
module irq_timer #(
    parameter int TIMER_DIV   = 200000,
    parameter int TIMER_WIDTH = 18
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr_pend,
    output logic pend
);

    logic [TIMER_WIDTH-1:0] count;
    logic                   tick;

    assign tick = en && (count == TIMER_WIDTH'(TIMER_DIV - 1));

    // Disabling parks the count at zero so re-enabling gives a full period.
    always_ff @(posedge CLK) begin
        if (RST)              count <= '0;
        else if (!en || tick) count <= '0;
        else                  count <= count + TIMER_WIDTH'(1);
    end

    // A tick in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST)           pend <= 1'b0;
        else if (tick)     pend <= 1'b1;
        else if (clr_pend) pend <= 1'b0;
    end

endmodule

// File: rtl/irq_ctrl.sv
// 68000 interrupt controller: IPL encoding plus vectored/autovector/spurious IACK response.
// Optional periodic timer source enabled by defining IRQ_CTRL_TIMER_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TIMER_DIV   = 200000,
    parameter int TIMER_WIDTH = 18,
    parameter int TIMER_LEVEL = 7
) (
    input logic       CLK,
    input logic       RST,
    irq_ctrl_if.slave bus
);

    logic [NUM_SRC-1:0] irq_p0, irq_p1;
    logic [NUM_SRC-1:0] mask, avec, pend_src;
    logic [NUM_SRC-1:0] resp_sel, resp_sel_nx;
    state_t             state, state_nx;
    resp_t              resp_kind, resp_kind_nx;
    logic               iack, tim_pend, tim_hit;
    logic [7:0]         lvl_set, rdata;
    logic [2:0]         ipl_n;
    logic [NUM_SRC-1:0] iack_n;
    logic               vpa_n, berr_n;
    logic               unused_wdata;

    assign unused_wdata = ^bus.REG_WDATA;
    assign iack         = (bus.FC == 3'b111) && !bus.AS_N;

    // Stage p0/p1: two-flop synchroniser, inverted to active-high
    always_ff @(posedge CLK) begin
        irq_p0 <= ~bus.IRQ_N;
        irq_p1 <= irq_p0;
    end

    assign pend_src = irq_p1 & mask;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mask <= '0;
            avec <= '0;
        end else if (bus.REG_WE) begin
            if (bus.REG_ADDR == REG_MASK) mask <= bus.REG_WDATA[NUM_SRC-1:0];
            if (bus.REG_ADDR == REG_AVEC) avec <= bus.REG_WDATA[NUM_SRC-1:0];
        end
    end

`ifdef IRQ_CTRL_TIMER_EN
    logic tim_en, tim_clr;

    always_ff @(posedge CLK) begin
        if (RST)                                           tim_en <= 1'b0;
        else if (bus.REG_WE && bus.REG_ADDR == REG_TCTL)   tim_en <= bus.REG_WDATA[0];
    end

    // Pending is cleared either by software or by the CPU taking the timer IACK.
    assign tim_clr = (bus.REG_WE && bus.REG_ADDR == REG_TCTL && bus.REG_WDATA[1])
                   || (state == IDLE && iack && tim_hit);
    assign tim_hit = (bus.ADDR_L == level_t'(TIMER_LEVEL)) && tim_pend;

    irq_timer #(
        .TIMER_DIV  (TIMER_DIV),
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .en      (tim_en),
        .clr_pend(tim_clr),
        .pend    (tim_pend)
    );
`else
    assign tim_pend = 1'b0;
    assign tim_hit  = 1'b0;
`endif

    assign lvl_set = {{(7 - NUM_SRC){1'b0}}, pend_src, 1'b0}
                   | (8'(tim_pend) << TIMER_LEVEL);

    // Stage p2: registered priority encode onto IPL_N
    always_ff @(posedge CLK) begin
        if (RST) ipl_n <= 3'b111;
        else     ipl_n <= ~highest_level(lvl_set);
    end

    always_comb begin
        rdata = '0;
        case (bus.REG_ADDR)
            REG_MASK: rdata[NUM_SRC-1:0] = mask;
            REG_AVEC: rdata[NUM_SRC-1:0] = avec;
`ifdef IRQ_CTRL_TIMER_EN
            REG_TCTL: rdata[1:0] = {tim_pend, tim_en};
`endif
            REG_PEND: rdata[NUM_SRC-1:0] = irq_p1;
            default:  rdata = '0;
        endcase
    end

    // Response decode for the level on ADDR_L; only latched on IACK entry.
    always_comb begin
        resp_kind_nx = SPUR;
        resp_sel_nx  = '0;
        if (tim_hit) begin
            resp_kind_nx = AVEC;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.ADDR_L == level_t'(i + 1) && pend_src[i]) begin
                    resp_kind_nx   = avec[i] ? AVEC : VEC;
                    resp_sel_nx[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)                        resp_kind <= NONE;
        else if (state == IDLE && iack) resp_kind <= resp_kind_nx;
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && iack) resp_sel <= resp_sel_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (iack)       state_nx = RESP;
            RESP:    if (bus.AS_N)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        vpa_n  = 1'b1;
        berr_n = 1'b1;
        iack_n = '1;
        if (state == RESP) begin
            case (resp_kind)
                AVEC:    vpa_n  = 1'b0;
                VEC:     iack_n = ~resp_sel;
                SPUR:    berr_n = 1'b0;
                default: vpa_n  = 1'b1;
            endcase
        end
    end

    assign bus.REG_RDATA = rdata;
    assign bus.IPL_N     = ipl_n;
    assign bus.IACK_N    = iack_n;
    assign bus.VPA_N     = vpa_n;
    assign bus.BERR_N    = berr_n;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised 68000 interrupt controller for the Mackerel system CPLD; the successor to the hard-wired timer/DUART/IDE IPL logic.
- Takes NUM_SRC active-low interrupt sources plus an internal periodic timer, and encodes the highest pending enabled level onto IPL_N.
- Decodes IACK cycles and answers each one with a per-source vectored acknowledge, an autovector (VPA_N), or a spurious-interrupt BERR_N.
- Runs on the CPU clock domain.

Parameters:
- NUM_SRC, 4, number of external sources (1..6); source i is fixed at IPL level i+1.
- TIMER_DIV, 200000, CLK cycles per timer tick (100 Hz at 20 MHz).
- TIMER_WIDTH, 18, width of the timer counter; must satisfy TIMER_DIV < 2**TIMER_WIDTH.
- TIMER_LEVEL, 7, IPL level of the timer; must not equal any source level (1..NUM_SRC).

Ports:
- CLK  in  1  CPU clock. This is the one clock.
- RST  in  1  reset, synchronous, active-high.
- IRQ_N  in  NUM_SRC  asynchronous level-sensitive requests, active-low.
- AS_N  in  1  CPU address strobe, active-low.
- FC  in  3  CPU function code.
- ADDR_L  in  3  A3..A1; carries the acknowledged level during IACK.
- REG_WE  in  1  one-cycle write strobe, already address-qualified by the decoder.
- REG_ADDR  in  2  register select.
- REG_WDATA  in  8  write data.
- REG_RDATA  out  8  read data (combinational from REG_ADDR).
- IPL_N  out  3  encoded priority to the CPU, active-low, registered.
- IACK_N  out  NUM_SRC  per-source vectored acknowledge, active-low.
- VPA_N  out  1  autovector request, active-low.
- BERR_N  out  1  spurious-IACK bus error, active-low.

Behaviour:
- Reset: IPL_N=3'b111, IACK_N all 1, VPA_N=1, BERR_N=1, MASK=0, AVEC=0, TCTL=0, timer count=0, timer pending=0, FSM in IDLE.
- Registers:
  - 0 = MASK[NUM_SRC-1:0]; 1 enables the source.
  - 1 = AVEC[NUM_SRC-1:0]; 1 = autovector, 0 = vectored.
  - 2 = TCTL: bit0 = timer enable; bit1 reads as timer pending; writing 1 to bit1 clears pending.
  - 3 = PEND, read-only: synchronised raw IRQ state, active-high.
  - Unused bits read 0.
- IRQ_N passes through a 2-flop synchroniser. Pending level set = synchronised requests AND MASK, plus the timer pending bit. IPL_N = inverse of the highest pending level, registered.
- Total latency from an IRQ_N fall to IPL_N change: 3 CLK.
- Timer:
  - When enabled, the counter increments each CLK.
  - When count == TIMER_DIV-1, the counter wraps to 0 and sets pending.
  - Clearing bit0 holds the count at 0; pending is kept.
  - A tick coinciding with a clear-write leaves pending set (set wins).
- IACK is detected when FC==3'b111 and AS_N==0.
- FSM states:
  - IDLE -> RESP on IACK detect. In that cycle, L = ADDR_L is evaluated once and the response is latched:
    - L==TIMER_LEVEL and timer pending: VPA_N=0, and timer pending clears in that cycle.
    - Source L-1 pending and enabled, with AVEC set: VPA_N=0.
    - Source L-1 pending and enabled, with AVEC clear: IACK_N[L-1]=0.
    - Otherwise (spurious): BERR_N=0.
  - RESP: hold the latched response. When AS_N returns to 1 -> IDLE, deasserting all responses on that edge.
  - AS_N is never sampled through a synchroniser here. VPA_N, IACK_N and BERR_N are mutually exclusive.
- Source deassertion during RESP does not alter the latched response.
- Register writes during RESP take effect on pending/IPL immediately, but not on the latched response.
- RST asserted mid-cycle returns all outputs to reset values on the next CLK edge.

Optional Feature:
- Macro: IRQ_CTRL_TIMER_EN.
- With the macro defined: timer, TCTL and the timer level are present as described.
- Without it: no counter logic, TCTL reads 0 and writes are ignored, and an IACK at TIMER_LEVEL is treated as a spurious IACK (BERR_N=0).

Decomposition:
- Package irq_ctrl_pkg holds:
  - register address constants (REG_MASK=0, REG_AVEC=1, REG_TCTL=2, REG_PEND=3);
  - the FSM state enum (IDLE, RESP);
  - the 3-bit level type;
  - the response-kind enum (NONE, AVEC, VEC, SPUR).
- One natural sub-module: irq_timer. It is parametrised by TIMER_DIV and TIMER_WIDTH, with enable, clear-pending and pending-out ports.

Test Plan:
- Reset, NUM_SRC=4, MASK=4'b0010, IRQ_N[1]=0 -> IPL_N=3'b101 (level 2) exactly 3 CLK later.
- IRQ_N[0] and IRQ_N[3] low, both masked in -> IPL_N=3'b011 (level 4). Release IRQ_N[3] -> IPL_N=3'b110.
- AVEC bit1=0, IACK cycle with ADDR_L=2 -> IACK_N=4'b1101 until AS_N rises; VPA_N and BERR_N stay 1. Repeat with AVEC bit1=1 -> VPA_N=0, IACK_N all 1.
- TIMER_DIV=10, TCTL=1 -> pending after 10 CLK, IPL_N=3'b000. IACK at level 7 -> VPA_N=0 and pending cleared. Next tick 10 CLK after the previous one.
- IACK at level 3 with no level-3 request -> BERR_N=0 only. With IRQ_CTRL_TIMER_EN undefined, an IACK at level 7 -> BERR_N=0.
- RST asserted while in RESP with IACK_N low -> all outputs at reset values after 1 CLK; a write to TCTL clear coincident with a tick -> pending remains 1.
